sprite_scan_engine: RTL and testbench
=====================================

SPRITE_SCAN_ENGINE -- requirements
Module: sprite_scan_engine

Interface
REQ-001 Parameter ANIM_PERIOD, default 30: frames per animation-phase toggle.
REQ-002 Parameter NUM_SLOTS, default 8: number of object slots, priority lowest index first.
REQ-003 pixel_clk  in  1  sole clock; reset is asynchronous, active-low.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 drawX  in  10  current pixel column (0-799).
REQ-006 drawY  in  10  current pixel row (0-524).
REQ-007 vde  in  1  active-video qualifier for drawX/drawY.
REQ-008 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-009 obj_we  in  1  object-table write strobe.
REQ-010 obj_idx  in  3  slot written.
REQ-011 obj_x, obj_y  in  10 each  sprite top-left corner.
REQ-012 obj_code  in  5  base sprite ROM code (0-10).
REQ-013 obj_en  in  1  slot enable.
REQ-014 sprt_addr  out  10  ROM address to the sprite ROM bank, registered.
REQ-015 sprt_s  out  5  ROM select to the sprite ROM bank, registered.
REQ-016 rom_data  in  3  palette code returned combinationally by the ROM bank.
REQ-017 pix_idx  out  3  palette code of winning sprite pixel; 0 = transparent.
REQ-018 pix_hit  out  1  a sprite's bounding box covers this pixel.
REQ-019 pix_slot  out  3  winning slot number.
REQ-020 anim_phase  out  1  current animation phase.

Function
REQ-021 Sprites SHALL be 32x32; hit for slot n iff obj_en and x<=drawX<x+32 and y<=drawY<y+32, evaluated in 11-bit unsigned arithmetic (no wrap at 1023).
REQ-022 With vde=0, no slot SHALL hit.
REQ-023 Lowest-index hitting slot SHALL win; lower-priority slots are not consulted, even where the winner's pixel is transparent.
REQ-024 Stage 1 (cycle N+1) SHALL register sprt_addr={row[4:0],col[4:0]} relative to the winner, sprt_s = effective code, and the hit/slot/vde state.
REQ-025 Stage 2 (cycle N+2) SHALL register pix_idx=rom_data if hit else 0, pix_hit, and pix_slot; total latency is 2 cycles.
REQ-026 With no hit, sprt_addr and sprt_s SHALL be 0 and pix_slot SHALL be 0.
REQ-027 Frame counter SHALL increment on frame_start, and on reaching ANIM_PERIOD-1 SHALL wrap to 0 and toggle anim_phase.
REQ-028 Effective code = base+1 when anim_phase=1 and base is 1, 5, 7 or 9 (two-frame sprites); otherwise base.
REQ-029 Base codes above 10 SHALL pass unmodified.

Reset
REQ-030 On reset_n low, all slots SHALL clear (en=0, x=y=code=0), frame counter=0, anim_phase=0, and sprt_addr, sprt_s, pix_idx, pix_hit, pix_slot=0.
REQ-031 On deassertion, the first valid output SHALL appear 2 cycles after the first qualified pixel; reset mid-frame discards in-flight pixels.

Configuration
REQ-032 With SPRITE_SHADOW_EN defined, writes SHALL go to a shadow table copied to the active table on frame_start; a write coincident with frame_start SHALL be included in that copy.
REQ-033 Without SPRITE_SHADOW_EN, writes SHALL update the active table on the next clock edge.

Structure
REQ-034 Package sprite_pkg SHALL hold the sprite-code constants (0-10), SPRITE_W=32, the NUM_SLOTS default, and the packed obj_t struct {en, x, y, code}.
REQ-035 Sub-module sprite_hit_sel SHALL implement the combinational per-slot compare and priority encode.

Verification
REQ-036 Slot0 at (100,50), code 0; drawX=105, drawY=52, vde=1 -> cycle+1: sprt_addr=69, sprt_s=0; cycle+2: pix_hit=1, pix_slot=0, pix_idx=rom_data.
REQ-037 Slots 2 and 5 overlap at pixel (200,200) -> pix_slot=2; with slot 2 disabled -> pix_slot=5.
REQ-038 Slot0 at x=1000 with drawX=1010 -> hit; drawX=8 -> no hit (no wrap).
REQ-039 Code 7 with ANIM_PERIOD=2: 2 frame_start pulses -> sprt_s=8; 2 more -> sprt_s=7.
REQ-040 SPRITE_SHADOW_EN: write slot0 x=300 mid-frame -> old position persists until frame_start, new position after; without the macro, new position applies the next cycle.
REQ-041 Assert reset_n mid-frame -> all outputs 0 immediately and table cleared; with vde=0 -> pix_hit=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite scan engine: sprite-code map,
// sprite geometry, object-table entry layout and small helper functions.
package sprite_pkg;

    localparam int SPRITE_W      = 32;
    localparam int NUM_SLOTS_DEF = 8;

    // Sprite ROM codes; the odd codes 1, 5, 7 and 9 have a second animation
    // frame stored at code+1.
    localparam logic [4:0] SPR_CODE_0  = 5'd0;
    localparam logic [4:0] SPR_CODE_1  = 5'd1;
    localparam logic [4:0] SPR_CODE_2  = 5'd2;
    localparam logic [4:0] SPR_CODE_3  = 5'd3;
    localparam logic [4:0] SPR_CODE_4  = 5'd4;
    localparam logic [4:0] SPR_CODE_5  = 5'd5;
    localparam logic [4:0] SPR_CODE_6  = 5'd6;
    localparam logic [4:0] SPR_CODE_7  = 5'd7;
    localparam logic [4:0] SPR_CODE_8  = 5'd8;
    localparam logic [4:0] SPR_CODE_9  = 5'd9;
    localparam logic [4:0] SPR_CODE_10 = 5'd10;

    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] code;
    } obj_t;

    // True when pos lies in [org, org+SPRITE_W); 11-bit math so a sprite
    // near 1023 does not wrap around to column/row 0.
    function automatic logic covers(input logic [9:0] pos, input logic [9:0] org);
        return ({1'b0, org} <= {1'b0, pos}) &&
               ({1'b0, pos} < ({1'b0, org} + 11'(SPRITE_W)));
    endfunction

    // Two-frame sprites step to their second frame while the phase is high.
    function automatic logic [4:0] eff_code(input logic [4:0] base, input logic phase);
        if (phase && (base == SPR_CODE_1 || base == SPR_CODE_5 ||
                      base == SPR_CODE_7 || base == SPR_CODE_9))
            return base + 5'd1;
        return base;
    endfunction

endpackage

// File: rtl/sprite_hit_sel.sv
// Combinational per-slot bounding-box compare and lowest-index priority
// select; returns the winner's slot, in-sprite row/column and base code.
module sprite_hit_sel
    import sprite_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF
) (
    input  obj_t       objs [NUM_SLOTS],
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic       vde,
    output logic       hit,
    output logic [2:0] slot,
    output logic [4:0] row,
    output logic [4:0] col,
    output logic [4:0] code
);

    // Scan from the highest slot down so the lowest hitting index is the
    // last assignment and therefore wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise a
        // no-hit path would leave them unassigned and infer latches.
        hit  = 1'b0;
        slot = '0;
        row  = '0;
        col  = '0;
        code = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (vde && objs[i].en && covers(draw_x, objs[i].x) && covers(draw_y, objs[i].y)) begin
                hit  = 1'b1;
                slot = 3'(i);
                row  = 5'(draw_y - objs[i].y);
                col  = 5'(draw_x - objs[i].x);
                code = objs[i].code;
            end
        end
    end

endmodule

// File: rtl/sprite_scan_engine.sv
// Sprite scan engine: object table, animation-phase counter and a two-stage
// pixel pipeline (ROM address/select, then palette code).
// Optional feature: define SPRITE_SHADOW_EN to buffer table writes in a
// shadow table that is copied to the active table on frame_start.
module sprite_scan_engine
    import sprite_pkg::*;
#(
    parameter int ANIM_PERIOD = 30,
    parameter int NUM_SLOTS   = NUM_SLOTS_DEF
) (
    input  logic       pixel_clk,
    input  logic       reset_n,
    input  logic [9:0] drawX,
    input  logic [9:0] drawY,
    input  logic       vde,
    input  logic       frame_start,
    input  logic       obj_we,
    input  logic [2:0] obj_idx,
    input  logic [9:0] obj_x,
    input  logic [9:0] obj_y,
    input  logic [4:0] obj_code,
    input  logic       obj_en,
    output logic [9:0] sprt_addr,
    output logic [4:0] sprt_s,
    input  logic [2:0] rom_data,
    output logic [2:0] pix_idx,
    output logic       pix_hit,
    output logic [2:0] pix_slot,
    output logic       anim_phase
);

    localparam int CNT_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

    obj_t             active [NUM_SLOTS];
    obj_t             new_obj;
    logic [CNT_W-1:0] frame_cnt;
    logic             sel_hit;
    logic [2:0]       sel_slot;
    logic [4:0]       sel_row;
    logic [4:0]       sel_col;
    logic [4:0]       sel_code;
    logic             s1_hit;
    logic             s1_vde;
    logic [2:0]       s1_slot;

    // Pack the write-port fields into one table entry.
    always_comb begin
        new_obj = '{en: obj_en, x: obj_x, y: obj_y, code: obj_code};
    end

`ifdef SPRITE_SHADOW_EN
    obj_t shadow      [NUM_SLOTS];
    obj_t shadow_next [NUM_SLOTS];

    // Shadow contents after this cycle's write, so a write landing on the
    // frame_start cycle is part of the copy.
    always_comb begin
        shadow_next = shadow;
        if (obj_we && (int'(obj_idx) < NUM_SLOTS))
            shadow_next[obj_idx] = new_obj;
    end

    // Shadow takes every write; active is refreshed only at frame start.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the table is built from flops rather than a RAM macro,
            // so clearing every entry on reset is legal and required here.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register update in
            // this block ordered as a simultaneous clock-edge transfer.
            shadow <= shadow_next;
            if (frame_start)
                active <= shadow_next;
        end
    end
`else
    // Writes go straight into the active table.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the table is built from flops rather than a RAM macro,
            // so clearing every entry on reset is legal and required here.
            for (int i = 0; i < NUM_SLOTS; i++)
                active[i] <= '0;
        end else if (obj_we && (int'(obj_idx) < NUM_SLOTS)) begin
            // NOTE: non-blocking assignments keep every register update in
            // this block ordered as a simultaneous clock-edge transfer.
            active[obj_idx] <= new_obj;
        end
    end
`endif

    // Count frames and flip the animation phase once per ANIM_PERIOD frames.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt  <= '0;
            anim_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CNT_W'(ANIM_PERIOD - 1)) begin
                frame_cnt  <= '0;
                anim_phase <= ~anim_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    sprite_hit_sel #(.NUM_SLOTS(NUM_SLOTS)) u_hit_sel (
        .objs   (active),
        .draw_x (drawX),
        .draw_y (drawY),
        .vde    (vde),
        .hit    (sel_hit),
        .slot   (sel_slot),
        .row    (sel_row),
        .col    (sel_col),
        .code   (sel_code)
    );

    // Stage 1: ROM address/select for the winner (all zero on no hit).
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            sprt_addr <= '0;
            sprt_s    <= '0;
            s1_hit    <= 1'b0;
            s1_vde    <= 1'b0;
            s1_slot   <= '0;
        end else begin
            sprt_addr <= {sel_row, sel_col};
            sprt_s    <= eff_code(sel_code, anim_phase);
            s1_hit    <= sel_hit;
            s1_vde    <= vde;
            s1_slot   <= sel_slot;
        end
    end

    // Stage 2: capture the ROM palette code; a miss is transparent.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_idx  <= '0;
            pix_hit  <= 1'b0;
            pix_slot <= '0;
        end else begin
            pix_idx  <= (s1_hit && s1_vde) ? rom_data : 3'd0;
            pix_hit  <= s1_hit && s1_vde;
            pix_slot <= s1_slot;
        end
    end

endmodule

// File: tb/tb_sprite_scan_engine.sv
// Self-checking bench for sprite_scan_engine with a behavioural model of the
// object table, frame count and pixel selection. Works with or without
// SPRITE_SHADOW_EN defined.
module tb_sprite_scan_engine;

    localparam int P  = 2;
    localparam int NS = 8;

    logic       pixel_clk = 1'b0;
    logic       reset_n;
    logic [9:0] drawX, drawY;
    logic       vde, frame_start, obj_we, obj_en;
    logic [2:0] obj_idx;
    logic [9:0] obj_x, obj_y;
    logic [4:0] obj_code;
    logic [9:0] sprt_addr;
    logic [4:0] sprt_s;
    logic [2:0] rom_data, pix_idx, pix_slot;
    logic       pix_hit, anim_phase;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: active and shadow tables, total frame_start count.
    int m_x[NS], m_y[NS], m_code[NS];
    bit m_en[NS];
    int s_x[NS], s_y[NS], s_code[NS];
    bit s_en[NS];
    int frames;

    always #5 pixel_clk = ~pixel_clk;

    // Stand-in sprite ROM contents.
    function automatic logic [2:0] rom_fn(input logic [9:0] a, input logic [4:0] s);
        return a[2:0] ^ a[7:5] ^ s[2:0];
    endfunction

    assign rom_data = rom_fn(sprt_addr, sprt_s);

    sprite_scan_engine #(.ANIM_PERIOD(P), .NUM_SLOTS(NS)) dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .drawX       (drawX),
        .drawY       (drawY),
        .vde         (vde),
        .frame_start (frame_start),
        .obj_we      (obj_we),
        .obj_idx     (obj_idx),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .obj_code    (obj_code),
        .obj_en      (obj_en),
        .sprt_addr   (sprt_addr),
        .sprt_s      (sprt_s),
        .rom_data    (rom_data),
        .pix_idx     (pix_idx),
        .pix_hit     (pix_hit),
        .pix_slot    (pix_slot),
        .anim_phase  (anim_phase)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    function automatic int model_phase();
        return (frames / P) % 2;
    endfunction

    function automatic void model_clear();
        frames = 0;
        for (int i = 0; i < NS; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_code[i] = 0; m_en[i] = 0;
            s_x[i] = 0; s_y[i] = 0; s_code[i] = 0; s_en[i] = 0;
        end
    endfunction

    // Model a table write, optionally on the same cycle as frame_start.
    function automatic void model_write(input int idx, input int x, input int y,
                                        input int code, input bit en, input bit fs);
`ifdef SPRITE_SHADOW_EN
        s_x[idx] = x; s_y[idx] = y; s_code[idx] = code; s_en[idx] = en;
        if (fs)
            for (int i = 0; i < NS; i++) begin
                m_x[i] = s_x[i]; m_y[i] = s_y[i]; m_code[i] = s_code[i]; m_en[i] = s_en[i];
            end
`else
        m_x[idx] = x; m_y[idx] = y; m_code[idx] = code; m_en[idx] = en;
`endif
        if (fs)
            frames++;
    endfunction

    function automatic void model_frame();
`ifdef SPRITE_SHADOW_EN
        for (int i = 0; i < NS; i++) begin
            m_x[i] = s_x[i]; m_y[i] = s_y[i]; m_code[i] = s_code[i]; m_en[i] = s_en[i];
        end
`endif
        frames++;
    endfunction

    // Expected pipeline result for one pixel: first enabled slot whose box
    // contains the pixel, offsets within the box, animated code.
    function automatic void model_px(input int dx, input int dy, input bit v,
                                     output bit h, output int slot,
                                     output int addr, output int s);
        int base;
        h = 0; slot = 0; addr = 0; s = 0;
        if (v) begin
            for (int i = 0; i < NS; i++) begin
                if (!h && m_en[i] && dx >= m_x[i] && dx < m_x[i] + 32 &&
                    dy >= m_y[i] && dy < m_y[i] + 32) begin
                    h    = 1;
                    slot = i;
                    addr = (dy - m_y[i]) * 32 + (dx - m_x[i]);
                    base = m_code[i];
                    if (model_phase() == 1 && (base == 1 || base == 5 || base == 7 || base == 9))
                        s = base + 1;
                    else
                        s = base;
                end
            end
        end
    endfunction

    task automatic write_obj(input int idx, input int x, input int y,
                             input int code, input bit en, input bit fs);
        obj_we = 1'b1; obj_idx = 3'(idx); obj_x = 10'(x); obj_y = 10'(y);
        obj_code = 5'(code); obj_en = en; frame_start = fs;
        step();
        obj_we = 1'b0; frame_start = 1'b0;
        model_write(idx, x, y, code, en, fs);
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        model_frame();
    endtask

    // Make pending writes visible in shadow builds; no-op otherwise.
    task automatic apply();
`ifdef SPRITE_SHADOW_EN
        frame_pulse();
`endif
    endtask

    task automatic check_pixel(input string tag, input int dx, input int dy, input bit v);
        bit h;
        int slot, addr, s;
        model_px(dx, dy, v, h, slot, addr, s);
        drawX = 10'(dx); drawY = 10'(dy); vde = v;
        step();
        check({tag, "_addr"}, 32'(sprt_addr), 32'(addr));
        check({tag, "_s"}, 32'(sprt_s), 32'(s));
        drawX = '0; drawY = '0; vde = 1'b0;
        step();
        check({tag, "_hit"}, 32'(pix_hit), 32'(h));
        check({tag, "_slot"}, 32'(pix_slot), 32'(slot));
        check({tag, "_idx"}, 32'(pix_idx),
              h ? 32'(rom_fn(10'(addr), 5'(s))) : 32'd0);
        check({tag, "_phase"}, 32'(anim_phase), 32'(model_phase()));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, 32'(sprt_addr), 32'd0);
        check({tag, "_s"}, 32'(sprt_s), 32'd0);
        check({tag, "_hit"}, 32'(pix_hit), 32'd0);
        check({tag, "_slot"}, 32'(pix_slot), 32'd0);
        check({tag, "_idx"}, 32'(pix_idx), 32'd0);
        check({tag, "_phase"}, 32'(anim_phase), 32'd0);
    endtask

    initial begin
        int rx, ry;
        reset_n = 1'b0; drawX = '0; drawY = '0; vde = 1'b0; frame_start = 1'b0;
        obj_we = 1'b0; obj_idx = '0; obj_x = '0; obj_y = '0; obj_code = '0; obj_en = 1'b0;
        model_clear();
        step();
        step();
        check_zero("reset");
        reset_n = 1'b1;
        step();

        // Basic hit: slot 0 at (100,50), code 0, pixel (105,52) -> addr 69.
        write_obj(0, 100, 50, 0, 1'b1, 1'b0);
        apply();
        check_pixel("basic", 105, 52, 1'b1);
        check_pixel("basic_miss", 99, 52, 1'b1);
        check_pixel("basic_edge", 131, 81, 1'b1);

        // Priority: slots 2 and 5 both cover (200,200).
        write_obj(2, 190, 185, 3, 1'b1, 1'b0);
        write_obj(5, 180, 195, 4, 1'b1, 1'b0);
        apply();
        check_pixel("prio_2", 200, 200, 1'b1);
        write_obj(2, 190, 185, 3, 1'b0, 1'b0);
        apply();
        check_pixel("prio_5", 200, 200, 1'b1);

        // No wrap past 1023.
        write_obj(0, 1000, 50, 2, 1'b1, 1'b0);
        apply();
        check_pixel("nowrap_hit", 1010, 55, 1'b1);
        check_pixel("nowrap_miss", 8, 55, 1'b1);
        check_pixel("vde_off", 1010, 55, 1'b0);

        // Animation: code 7 alternates with 8 every P frames.
        write_obj(0, 1000, 50, 7, 1'b1, 1'b0);
        apply();
        frame_pulse();
        frame_pulse();
        check_pixel("anim_a", 1005, 60, 1'b1);
        frame_pulse();
        frame_pulse();
        check_pixel("anim_b", 1005, 60, 1'b1);
        write_obj(0, 1000, 50, 9, 1'b1, 1'b0);
        write_obj(1, 400, 400, 12, 1'b1, 1'b0);
        apply();
        frame_pulse();
        frame_pulse();
        check_pixel("anim_9", 1005, 60, 1'b1);
        check_pixel("code_12", 410, 410, 1'b1);

        // Move slot 0 mid-frame: old vs new position before/after frame_start.
        write_obj(0, 300, 100, 1, 1'b1, 1'b0);
        check_pixel("move_old", 1005, 60, 1'b1);
        check_pixel("move_new", 305, 105, 1'b1);
        frame_pulse();
        check_pixel("move_old_f", 1005, 60, 1'b1);
        check_pixel("move_new_f", 305, 105, 1'b1);

        // Write landing on the frame_start cycle.
        write_obj(3, 600, 300, 6, 1'b1, 1'b1);
        check_pixel("coinc", 610, 310, 1'b1);

        // Randomized tables, pixels and frame pulses.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NS; i++) begin
                rx = ($urandom % 5 == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 100);
                ry = $urandom_range(0, 100);
                write_obj(i, rx, ry, $urandom_range(0, 15), ($urandom % 4) != 0, 1'b0);
            end
            apply();
            for (int k = 0; k < 20; k++) begin
                rx = ($urandom % 5 == 0) ? $urandom_range(980, 1023) : $urandom_range(0, 140);
                ry = $urandom_range(0, 140);
                if ($urandom % 6 == 0)
                    frame_pulse();
                check_pixel("rand", rx, ry, ($urandom % 10) != 0);
            end
        end

        // Reset mid-frame with a hit in flight.
        write_obj(0, 100, 50, 5, 1'b1, 1'b0);
        apply();
        frame_pulse();
        frame_pulse();
        drawX = 10'd110; drawY = 10'd60; vde = 1'b1;
        step();
        drawX = '0; drawY = '0; vde = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        model_clear();
        step();
        reset_n = 1'b1;
        step();
        check_zero("post_reset");
        check_pixel("cleared", 110, 60, 1'b1);
        check_pixel("cleared_vde0", 110, 60, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
